// File: rtl/ascon_perm_engine_if.sv
// Load-stream handshake and state outputs of the Ascon permutation engine.
// The engine takes the slave side; the loader / state consumer takes the master side.
interface ascon_perm_engine_if;
  logic        load_valid;
  logic [15:0] din;
  logic        load_ready;
  logic [63:0] S_0_reg;
  logic [63:0] S_1_reg;
  logic [63:0] S_2_reg;
  logic [63:0] S_3_reg;
  logic [63:0] S_4_reg;
  logic        rounds_done;

  modport master (
    output load_valid, din,
    input  load_ready, S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg, rounds_done
  );

  modport slave (
    input  load_valid, din,
    output load_ready, S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg, rounds_done
  );
endinterface

// File: rtl/ascon_perm_engine.sv
// Ascon permutation engine: assembles the 320-bit state from 16-bit load words,
// runs ROUNDS rounds one per cycle, optionally folds the key into x3/x4, then holds.
module ascon_perm_engine #(
  parameter int ROUNDS     = 12,
  parameter bit KEY_XOR_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  ascon_perm_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t         state;
  state_t         next_state;
  logic [319:0]   st;
  logic [127:0]   key;
  logic [4:0]     word_cnt;
  logic [3:0]     round_cnt;
  logic           ready;
  logic           done;
  logic           accept;
  logic           last_word;
  logic           last_round;
  logic           do_round;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One full round with round index i; kx folds the key into x3||x4 afterwards.
  function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] i,
                                            input logic kx, input logic [127:0] k);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [7:0]  rc;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    rc = 8'hF0 - ({4'd0, i} * 8'h0F);
    x2 = x2 ^ {56'd0, rc};
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    if (kx) begin
      x3 = x3 ^ k[127:64];
      x4 = x4 ^ k[63:0];
    end else begin
      x3 = x3;
      x4 = x4;
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: next_state = accept ? LOAD : state;
      LOAD:       next_state = (accept && last_word) ? RUN : LOAD;
      RUN:        next_state = last_round ? DONE : RUN;
      default:    next_state = IDLE;
    endcase
  end

  // FSM decode of the current cycle's actions
  always_comb begin
    accept     = bus.load_valid && ready;
    last_word  = (word_cnt == 5'd19);
    last_round = (round_cnt == 4'd11);
    do_round   = (state == RUN);
  end

  // Handshake/status flags registered from the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      ready <= (next_state != RUN);
      done  <= (next_state == DONE);
    end
  end

  // Word and round counters; round index starts at 12-ROUNDS
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= 5'd0;
      round_cnt <= 4'd0;
    end else begin
      if (accept) word_cnt <= last_word ? 5'd0 : word_cnt + 5'd1;
      if (accept && last_word)        round_cnt <= 4'(12 - ROUNDS);
      else if (do_round && !last_round) round_cnt <= round_cnt + 4'd1;
    end
  end

  // State and key datapath: slot writes while loading, one round per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= 320'd0;
      key <= 128'd0;
    end else if (accept) begin
      for (int j = 0; j < 20; j++) begin
        if (word_cnt == 5'(j)) st[319 - 16*j -: 16] <= bus.din;
      end
      for (int j = 0; j < 8; j++) begin
        if (word_cnt == 5'(j + 4)) key[127 - 16*j -: 16] <= bus.din;
      end
    end else if (do_round) begin
      st <= round_fn(st, round_cnt, last_round && KEY_XOR_EN, key);
    end
  end

  assign bus.S_0_reg     = st[319:256];
  assign bus.S_1_reg     = st[255:192];
  assign bus.S_2_reg     = st[191:128];
  assign bus.S_3_reg     = st[127:64];
  assign bus.S_4_reg     = st[63:0];
  assign bus.load_ready  = ready;
  assign bus.rounds_done = done;

endmodule

// File: doc/ascon_perm_engine.md
# ascon_perm_engine

Ascon permutation engine that builds the 320-bit Ascon state from a 16-bit load stream (IV‖K‖N) and runs p^a rounds, one per cycle. It then applies the initialization key XOR and holds the result with `rounds_done` high. It sits directly upstream of the output state controller, which consumes `S_0_reg`..`S_4_reg` and steps one double-byte per cycle while `rounds_done` is high.

## Interface
- `ROUNDS`, default 12: rounds per run, legal 1..12. Round constants start at index 12−ROUNDS.
- `KEY_XOR_EN`, default 1: when 1, XOR the 128-bit key into S3‖S4 after the last round.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_valid`  in  1  `din` holds a valid load word this cycle.
- `din`  in  16  load word.
- `load_ready`  out  1  engine accepts a load word this cycle.
- `S_0_reg`..`S_4_reg`  out  64 each  Ascon state words x0..x4 (registered).
- `rounds_done`  out  1  level; state is final and stable.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- `load_ready` = 1 in IDLE, LOAD and DONE; 0 in RUN.
- A word is accepted on a rising edge with `load_valid && load_ready`.
- Load order: 20 words, MSB-first across the concatenated state S0[63:48], S0[47:32], … , S4[15:0].
  - Accepted word w (0..19) is written to word slot w; other slots are untouched.
  - A 5-bit word counter wraps to 0 after word 19.
- Words 4..11 (S1‖S2) are also captured into a 128-bit key register.
- Transitions:
  - IDLE/DONE → LOAD on the first accepted word. `rounds_done` clears on that edge.
  - LOAD → RUN on acceptance of word 19.
  - RUN → DONE after round ROUNDS−1.
  - DONE holds until a new load begins.
- `load_valid` in RUN is ignored. Gaps in `load_valid` during LOAD stall the counter.
- A round r (round counter i = 12−ROUNDS+r) updates the whole state in one cycle:
  - Constant: x2 ^= {56'b0, 8'hF0 − i·8'h0F}. For ROUNDS=12 the constants run F0, E1, D2, … , 4B.
  - S-box, bitsliced over 64 columns:
    - x0^=x4; x4^=x3; x2^=x1.
    - t_k = ~x_k & x_(k+1 mod 5).
    - x_k ^= t_(k+1 mod 5).
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer (rotr = rotate right):
    - x0 ^= rotr19 ^ rotr28
    - x1 ^= rotr61 ^ rotr39
    - x2 ^= rotr1 ^ rotr6
    - x3 ^= rotr10 ^ rotr17
    - x4 ^= rotr7 ^ rotr41
- If KEY_XOR_EN=1, the last round's result is also XORed with {S3,S4} ^= key on the same edge. There is no extra cycle.
- All arithmetic is bitwise and modulo-free. The constant subtraction is 8-bit and cannot underflow for i ≤ 11.

## Timing
- Reset (`rst` high at an edge) clears:
  - `S_0_reg`..`S_4_reg` = 0
  - key register = 0
  - word and round counters = 0
  - FSM = IDLE
  - `rounds_done` = 0, so `load_ready` = 1
- Reset mid-LOAD or mid-RUN aborts the run. Partial state is discarded (zeroed). Reset has priority over every other event.
- Word 19 is accepted at edge T. Rounds are applied at edges T+1..T+ROUNDS. `rounds_done` = 1 after edge T+ROUNDS.
- `S_*_reg` change only on accepted load edges and RUN edges. They are stable for the entire DONE interval.
- In DONE, `load_valid` at edge D: word 0 is written to S0[63:48], `rounds_done` = 0 after D, FSM = LOAD. Downstream must treat the state as invalid from then on.
- Throughput: 20 + ROUNDS cycles per run minimum. Back-to-back loads are allowed with no dead cycle after DONE.

## Test plan
- Reset: assert `rst` 2 cycles → all `S_*_reg` = 0, `rounds_done` = 0, `load_ready` = 1. Then 5 idle cycles → no change.
- Ascon-128 init KAT (ROUNDS=12, KEY_XOR_EN=1):
  - Stimulus: IV = 0x80400C0600000000, K = N = 0x000102…0F, loaded as 20 contiguous words.
  - Required: `rounds_done` rises exactly 12 cycles after word 19, and `S_0_reg`..`S_4_reg` match the Ascon C reference model bit-exactly.
- Single round (ROUNDS=1, KEY_XOR_EN=0), all-zero load:
  - Constant used is 0x4B.
  - Required: `rounds_done` 1 cycle after word 19, state equal to the model's p^1 of zero. Repeat with ROUNDS=6, where the first constant is 0x96.
- Stalls and busy:
  - Random `load_valid` gaps during LOAD → same result as contiguous load.
  - `load_valid` pulses during RUN → `load_ready` = 0, state and timing unaffected.
- Reload from DONE: start a second load → `rounds_done` falls the next cycle. The second result matches the model and is independent of the first run.
- Reset at round 5 of RUN → all outputs 0 and IDLE. An immediate full reload then produces the correct KAT result.
